mem_fill: RTL

MEM_FILL -- requirements
Module: mem_fill

---
 rtl/mem_fill_pkg.sv | 37 +++
 rtl/mem_fill_if.sv | 27 ++
 rtl/mem_fill.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_fill_pkg.sv
// Shared types and the fill-pattern function for mem_fill, also usable by checkers.
package mem_fill_pkg;

    // Widest ADDR_W/DATA_W the pattern function handles; callers truncate the result.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        MODE_IDENT = 2'd0,
        MODE_CONST = 2'd1,
        MODE_DESC  = 2'd2,
        MODE_XOR   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Data word for counter value cnt; modulo-2**MAX_W arithmetic keeps truncation exact.
    function automatic logic [MAX_W-1:0] fill_pattern(
        input mode_t            mode,
        input logic [MAX_W-1:0] cnt,
        input logic [MAX_W-1:0] fill,
        input logic [MAX_W-1:0] depth
    );
        logic [MAX_W-1:0] data;
        case (mode)
            MODE_IDENT: data = cnt;
            MODE_CONST: data = fill;
            MODE_DESC:  data = depth - MAX_W'(1) - cnt;
            default:    data = cnt ^ fill;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/mem_fill_if.sv
// Start/config request and memory write port of mem_fill; the block itself is the slave.
interface mem_fill_if
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              en;
    mode_t             mode;
    logic [DATA_W-1:0] fill;
    logic              stall;
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
    logic              done;

    modport master (
        output en, mode, fill, stall,
        input  rdy, addr, wrdata, wren, done
    );

    modport slave (
        input  en, mode, fill, stall,
        output rdy, addr, wrdata, wren, done
    );
endinterface

// File: rtl/mem_fill.sv
// Fills DEPTH consecutive words starting at address 0 with a selectable pattern,
// one word per non-stalled cycle, then pulses done for one cycle.
module mem_fill
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input logic       clk,
    input logic       rst_n,
    mem_fill_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    mode_t             mode_q;
    logic [DATA_W-1:0] fill_q;
    logic              start;
    logic              last;
    logic [DATA_W-1:0] pattern;

    logic              rdy;
    logic              wren;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;

    assign last    = (cnt == LAST);
    assign pattern = DATA_W'(fill_pattern(mode_q, MAX_W'(cnt), MAX_W'(fill_q), MAX_W'(DEPTH)));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= MODE_IDENT;
            fill_q <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                cnt    <= '0;
                mode_q <= bus.mode;
                fill_q <= bus.fill;
            end else if (wren && !last) begin
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        rdy        = 1'b0;
        wren       = 1'b0;
        done       = 1'b0;
        addr       = '0;
        wrdata     = '0;
        unique case (state)
            IDLE: begin
                rdy = 1'b1;
                if (bus.en) begin
                    start      = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                addr   = cnt;
                wrdata = pattern;
                wren   = !bus.stall;
                // Leave only once the last word is actually written.
                if (wren && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.rdy    = rdy;
    assign bus.wren   = wren;
    assign bus.done   = done;
    assign bus.addr   = addr;
    assign bus.wrdata = wrdata;

endmodule
